// File: rtl/program_counter.sv
// Program counter and call/return sequencer driving the Instruction_Stack push/pop port.
// Keeps its own copy of the stack depth so it can refuse calls when full and returns when empty.
module program_counter #(
  parameter int                    addr_width = 4,
  parameter int                    data_width = 16,
  parameter logic [data_width-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  jump,
  input  logic                  call_req,
  input  logic                  rtrn_req,
  input  logic [data_width-1:0] i_target,
  input  logic [data_width-1:0] i_Stack,
  output logic [data_width-1:0] o_PC,
  output logic [data_width-1:0] o_Stack_PC,
  output logic                  o_call,
  output logic                  o_rtrn,
  output logic                  busy,
  output logic [addr_width:0]   o_depth,
  output logic                  o_overflow,
  output logic                  o_underflow,
  output logic                  dbg_state
);

  typedef enum logic {
    RUN      = 1'b0,
    RET_WAIT = 1'b1
  } state_t;

  localparam logic [addr_width:0] DEPTH_FULL = (addr_width + 1)'(2 ** addr_width);
  localparam logic [addr_width:0] DEPTH_ONE  = (addr_width + 1)'(1);

  state_t state;
  logic   full;
  logic   empty;
  logic   in_run;

  assign full   = (o_depth == DEPTH_FULL);
  assign empty  = (o_depth == '0);
  assign in_run = (state == RUN);

  // Stack port: o_call / o_rtrn are single-cycle strobes taken by the stack on the
  // same rising edge; the stack always accepts, so there is no ready. A push stores
  // o_Stack_PC (the stack adds 1); a popped address appears on i_Stack one edge later.
  assign o_call     = in_run && !rtrn_req && call_req && !full;
  assign o_rtrn     = in_run && rtrn_req && !empty;
  assign o_Stack_PC = o_PC;
  assign busy       = (state == RET_WAIT);
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      o_PC        <= RESET_PC;
      o_depth     <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (rtrn_req) begin
            // A refused return is dropped outright rather than falling through.
            if (!empty) begin
              o_depth <= o_depth - DEPTH_ONE;
              state   <= RET_WAIT;
            end else begin
              o_underflow <= 1'b1;
            end
          end else if (call_req) begin
            if (!full) begin
              o_PC    <= i_target;
              o_depth <= o_depth + DEPTH_ONE;
            end else begin
              o_overflow <= 1'b1;
            end
          end else if (jump) begin
            o_PC <= i_target;
          end else if (en) begin
            o_PC <= o_PC + data_width'(1);
          end
        end
        RET_WAIT: begin
          o_PC  <= i_Stack;
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter with a behavioural Instruction_Stack attached.
// Table-driven single-cycle vectors plus hand-written call/return/reset sequences.
module tb_program_counter;

  logic        clk;
  logic        rst;
  logic        en;
  logic        jump;
  logic        call_req;
  logic        rtrn_req;
  logic [15:0] i_target;
  logic [15:0] i_Stack;
  logic [15:0] o_PC;
  logic [15:0] o_Stack_PC;
  logic        o_call;
  logic        o_rtrn;
  logic        busy;
  logic [4:0]  o_depth;
  logic        o_overflow;
  logic        o_underflow;
  logic        dbg_state;

  program_counter #(
    .addr_width(4),
    .data_width(16),
    .RESET_PC  (16'h0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .jump       (jump),
    .call_req   (call_req),
    .rtrn_req   (rtrn_req),
    .i_target   (i_target),
    .i_Stack    (i_Stack),
    .o_PC       (o_PC),
    .o_Stack_PC (o_Stack_PC),
    .o_call     (o_call),
    .o_rtrn     (o_rtrn),
    .busy       (busy),
    .o_depth    (o_depth),
    .o_overflow (o_overflow),
    .o_underflow(o_underflow),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural Instruction_Stack ----------------
  logic [15:0] stk_mem [16];
  logic [4:0]  stk_sp;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      stk_sp <= '0;
    end else if (o_call) begin
      stk_mem[stk_sp[3:0]] <= o_Stack_PC + 16'd1;
      stk_sp               <= stk_sp + 5'd1;
    end else if (o_rtrn) begin
      i_Stack <= stk_mem[stk_sp[3:0] - 4'd1];
      stk_sp  <= stk_sp - 5'd1;
    end
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_pc;
  logic        exp_ovf;
  logic        exp_udf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    en = 1'b0; jump = 1'b0; call_req = 1'b0; rtrn_req = 1'b0; i_target = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_jump(input logic [15:0] tgt);
    @(negedge clk);
    jump = 1'b1; i_target = tgt;
    @(posedge clk); #1;
    clear_inputs();
    exp_pc = tgt;
    chk("jump_pc", o_PC, exp_pc);
  endtask

  task automatic do_call(input logic [15:0] tgt);
    logic ok;
    ok = (exp_q.size() < 16);
    @(negedge clk);
    call_req = 1'b1; i_target = tgt;
    #1;
    chk("call_strobe", o_call, ok);
    chk("call_no_rtrn", o_rtrn, 0);
    chk("call_stack_pc", o_Stack_PC, exp_pc);
    if (ok) begin
      exp_q.push_back(exp_pc + 16'd1);
      exp_pc = tgt;
    end else begin
      exp_ovf = 1'b1;
    end
    @(posedge clk); #1;
    clear_inputs();
    chk("call_pc", o_PC, exp_pc);
    chk("call_depth", o_depth, exp_q.size());
    chk("call_overflow", o_overflow, exp_ovf);
  endtask

  // with_call also raises call_req to confirm the return wins.
  task automatic do_return(input logic with_call);
    logic ok;
    ok = (exp_q.size() > 0);
    @(negedge clk);
    rtrn_req = 1'b1; call_req = with_call; i_target = 16'h7777;
    #1;
    chk("rtrn_strobe", o_rtrn, ok);
    chk("rtrn_no_call", o_call, 0);
    @(posedge clk); #1;
    if (ok) begin
      // Requests raised while busy must be ignored.
      rtrn_req = 1'b1; call_req = 1'b1; jump = 1'b1; en = 1'b1; i_target = 16'hDEAD;
      chk("wait_busy", busy, 1);
      chk("wait_state", dbg_state, 1);
      chk("wait_call", o_call, 0);
      chk("wait_rtrn", o_rtrn, 0);
      chk("wait_pc_hold", o_PC, exp_pc);
      chk("wait_depth", o_depth, exp_q.size() - 1);
      @(posedge clk); #1;
      clear_inputs();
      exp_pc = exp_q.pop_back();
      chk("rtrn_pc", o_PC, exp_pc);
      chk("rtrn_busy_clear", busy, 0);
      chk("rtrn_depth", o_depth, exp_q.size());
    end else begin
      clear_inputs();
      exp_udf = 1'b1;
      chk("udf_flag", o_underflow, 1);
      chk("udf_pc_hold", o_PC, exp_pc);
      chk("udf_busy", busy, 0);
      chk("udf_depth", o_depth, 0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rtrn;
    logic        call;
    logic        jmp;
    logic        en;
    logic [15:0] target;
    logic        exp_call;
    logic [15:0] exp_pc;
    logic [4:0]  exp_depth;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'd1,    5'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'd2,    5'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'd3,    5'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b0, 16'hFFFF, 5'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 5'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd10,   1'b0, 16'd10,   5'd0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd40,   1'b1, 16'd40,   5'd1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'd5,    1'b0, 16'd5,    5'd1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd99,   1'b0, 16'd5,    5'd1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0030, 1'b1, 16'h0030, 5'd2};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0031, 5'd2};
  end

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1;
    clear_inputs();
    exp_pc = 16'h0000; exp_ovf = 1'b0; exp_udf = 1'b0;

    // Asynchronous reset mid-cycle, checked before any clock edge.
    #1 rst = 1'b0;
    #1;
    chk("rst_pc", o_PC, 16'h0000);
    chk("rst_depth", o_depth, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_udf", o_underflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rtrn_req = vecs[i].rtrn; call_req = vecs[i].call;
      jump = vecs[i].jmp; en = vecs[i].en; i_target = vecs[i].target;
      #1;
      chk($sformatf("vec%0d_call", i), o_call, vecs[i].exp_call);
      chk($sformatf("vec%0d_stack_pc", i), o_Stack_PC, exp_pc);
      if (vecs[i].exp_call) exp_q.push_back(exp_pc + 16'd1);
      @(posedge clk); #1;
      exp_pc = vecs[i].exp_pc;
      chk($sformatf("vec%0d_pc", i), o_PC, vecs[i].exp_pc);
      chk($sformatf("vec%0d_depth", i), o_depth, vecs[i].exp_depth);
    end
    clear_inputs();

    // Return to 'h6 (from the call at 5), then to 11 (from the call at 10).
    do_return(1'b0);
    chk("ret1_pc", o_PC, 16'd6);
    do_return(1'b0);
    chk("ret2_pc", o_PC, 16'd11);

    // Nine nested calls from 'h10..'h90, then unwind.
    do_jump(16'h0010);
    for (int k = 1; k <= 9; k++) do_call(16'((k + 1) * 16'h10));
    for (int k = 9; k >= 1; k--) begin
      do_return(1'b0);
      chk("nest_pc", o_PC, 16'(k * 16'h10 + 1));
    end
    chk("nest_depth_end", o_depth, 0);

    // Fill the stack, then overflow.
    for (int k = 0; k < 16; k++) do_call(16'(16'h100 + k));
    chk("full_depth", o_depth, 16);
    do_call(16'h0999);
    chk("ovf_pc_hold", o_PC, 16'h010F);

    // Simultaneous call and return: return wins.
    do_return(1'b1);
    chk("both_depth", o_depth, 15);

    // Drain and underflow.
    while (exp_q.size() > 0) do_return(1'b0);
    do_return(1'b0);
    do_return(1'b1);
    chk("flags_sticky_ovf", o_overflow, 1);

    // Reset while waiting for the popped address.
    do_jump(16'h0200);
    do_call(16'h0300);
    @(negedge clk);
    rtrn_req = 1'b1;
    @(posedge clk); #1;
    clear_inputs();
    chk("rw_busy", busy, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rw_rst_pc", o_PC, 16'h0000);
    chk("rw_rst_busy", busy, 0);
    chk("rw_rst_state", dbg_state, 0);
    chk("rw_rst_depth", o_depth, 0);
    chk("rw_rst_flags", {o_overflow, o_underflow}, 0);
    @(posedge clk); #1;
    chk("rw_no_stale_pc", o_PC, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    exp_pc = 16'h0000; exp_ovf = 1'b0; exp_udf = 1'b0;
    do_call(16'h0055);
    do_return(1'b0);
    chk("post_rst_ret_pc", o_PC, 16'h0001);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
